// File: rtl/rf_param_io.sv
// rf_param_io: N x W register file with an input-port register (valid/ready in) and an output-port register (valid/ready out).
// Optional macro RF_BYPASS_EN forwards write data to the read ports (never for the input-port register).
module rf_param_io #(
    parameter int W       = 5,
    parameter int N       = 4,
    parameter int IN_IDX  = 2,
    parameter int OUT_IDX = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [$clog2(N)-1:0]   ra,
    input  logic [$clog2(N)-1:0]   rb,
    input  logic                   we,
    input  logic [$clog2(N)-1:0]   wa,
    input  logic [W-1:0]           wd,
    output logic [W-1:0]           a,
    output logic [W-1:0]           b,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_ack,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_ovf,
    output logic [N*W-1:0]         regs_flat
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] IN_A  = AW'(IN_IDX);
    localparam logic [AW-1:0] OUT_A = AW'(OUT_IDX);

    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];
    logic         in_full_q, in_full_d;
    logic         out_valid_q, out_valid_d;
    logic         out_ovf_q, out_ovf_d;
    logic         wr_out, in_xfer;

    always_comb begin
        wr_out  = we && wa == OUT_A;
        in_xfer = in_valid && !in_full_q;
        regs_d  = regs_q;
        if (we && wa != IN_A) regs_d[wa] = wd;
        if (in_xfer) regs_d[IN_IDX] = in_data;
        in_full_d   = in_full_q ? !in_ack : in_xfer;
        // a write coinciding with a completed handshake replaces data that was just taken, so no overflow
        out_valid_d = wr_out || (out_valid_q && !out_ready);
        out_ovf_d   = out_ovf_q || (wr_out && out_valid_q && !out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q      <= '{default: '0};
            in_full_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            in_full_q   <= in_full_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

`ifdef RF_BYPASS_EN
    assign a = (we && wa == ra && wa != IN_A) ? wd : regs_q[ra];
    assign b = (we && wa == rb && wa != IN_A) ? wd : regs_q[rb];
`else
    assign a = regs_q[ra];
    assign b = regs_q[rb];
`endif

    assign in_ready  = !in_full_q;
    assign out_data  = regs_q[OUT_IDX];
    assign out_valid = out_valid_q;
    assign out_ovf   = out_ovf_q;

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign regs_flat[i*W +: W] = regs_q[i];
    end
endmodule

// File: tb/tb_rf_param_io.sv
// tb_rf_param_io: directed scoreboard bench for rf_param_io (default 4x5 and an 8x8 instance).
module tb_rf_param_io;
    localparam int SIG_A = 0, SIG_B = 1, SIG_IRDY = 2, SIG_OVLD = 3, SIG_ODAT = 4, SIG_OVF = 5, SIG_FLAT8 = 6, SIG_A8 = 7;

    typedef struct {
        int          sig;
        logic [63:0] exp;
        string       name;
    } chk_t;

    logic clk = 0, reset = 0;
    logic [1:0] ra = 0, rb = 0, wa = 0;
    logic we = 0, in_valid = 0, in_ack = 0, out_ready = 0;
    logic [4:0] wd = 0, in_data = 0;
    logic [4:0] a, b, out_data;
    logic in_ready, out_valid, out_ovf;
    logic [19:0] regs_flat;

    logic [2:0] ra8 = 0, rb8 = 0, wa8 = 0;
    logic we8 = 0, in_valid8 = 0, in_ack8 = 0, out_ready8 = 1;
    logic [7:0] wd8 = 0, in_data8 = 0;
    logic [7:0] a8, b8, out_data8;
    logic in_ready8, out_valid8, out_ovf8;
    logic [63:0] regs_flat8;

    chk_t        exp_q [$];
    logic [4:0]  out_q [$];
    chk_t        cur;
    logic [63:0] act;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    rf_param_io dut (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .we(we), .wa(wa), .wd(wd), .a(a), .b(b),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_ack(in_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ovf(out_ovf),
        .regs_flat(regs_flat)
    );

    rf_param_io #(.W(8), .N(8), .IN_IDX(2), .OUT_IDX(3)) dut8 (
        .clk(clk), .reset(reset), .ra(ra8), .rb(rb8), .we(we8), .wa(wa8), .wd(wd8), .a(a8), .b(b8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8), .in_ack(in_ack8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8), .out_ovf(out_ovf8),
        .regs_flat(regs_flat8)
    );

    function automatic logic [63:0] sample(int s);
        case (s)
            SIG_A:     return 64'(a);
            SIG_B:     return 64'(b);
            SIG_IRDY:  return 64'(in_ready);
            SIG_OVLD:  return 64'(out_valid);
            SIG_ODAT:  return 64'(out_data);
            SIG_OVF:   return 64'(out_ovf);
            SIG_FLAT8: return regs_flat8;
            SIG_A8:    return 64'(a8);
            default:   return 'x;
        endcase
    endfunction

    // Monitor: compares queued expectations and observed output transfers away from the active edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            act = sample(cur.sig);
            n_chk++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", cur.name, act, cur.exp);
            end
        end
        if (reset && out_valid && out_ready) begin
            n_chk++;
            if (out_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_xfer: unexpected transfer of %0h", out_data);
            end else if (out_data !== out_q[0]) begin
                n_fail++;
                $display("FAIL out_xfer: got %0h, expected %0h", out_data, out_q[0]);
                void'(out_q.pop_front());
            end else void'(out_q.pop_front());
        end
    end

    task automatic expect_val(input int s, input logic [63:0] v, input string n);
        exp_q.push_back('{sig: s, exp: v, name: n});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        expect_val(SIG_IRDY, 1, "rst_in_ready");
        expect_val(SIG_OVLD, 0, "rst_out_valid");
        expect_val(SIG_OVF, 0, "rst_out_ovf");
        expect_val(SIG_A, 0, "rst_a");
        tick();
        tick();
        reset = 1;
        tick();
        we = 1; wa = 0; wd = 5'h15;
        tick();
        we = 0; ra = 0;
        expect_val(SIG_A, 5'h15, "write_read");
        tick();
        we = 1; wa = 3; wd = 5'h1E;
        tick();
        we = 0;
        expect_val(SIG_OVLD, 1, "pre_reset_out_valid");
        tick();
        reset = 0;
        expect_val(SIG_A, 0, "async_rst_a");
        expect_val(SIG_IRDY, 1, "async_rst_in_ready");
        expect_val(SIG_OVLD, 0, "async_rst_out_valid");
        expect_val(SIG_ODAT, 0, "async_rst_out_data");
        tick();
        reset = 1;
        tick();
        in_valid = 1; in_data = 5'h0A; rb = 2;
        tick();
        in_data = 5'h1F;
        expect_val(SIG_IRDY, 0, "in_full_ready");
        expect_val(SIG_B, 5'h0A, "in_accept");
        tick();
        expect_val(SIG_B, 5'h0A, "in_hold_ignored");
        expect_val(SIG_IRDY, 0, "in_still_full");
        in_ack = 1;
        tick();
        in_ack = 0;
        expect_val(SIG_IRDY, 1, "in_ack_ready");
        expect_val(SIG_B, 5'h0A, "in_ack_retain");
        tick();
        in_valid = 0;
        expect_val(SIG_B, 5'h1F, "in_second_accept");
        expect_val(SIG_IRDY, 0, "in_second_full");
        tick();
        we = 1; wa = 2; wd = 5'h07; ra = 2;
        expect_val(SIG_A, 5'h1F, "no_fwd_in_idx");
        tick();
        we = 0;
        expect_val(SIG_B, 5'h1F, "write_in_idx_ignored");
        in_ack = 1;
        tick();
        in_ack = 0;
        expect_val(SIG_IRDY, 1, "in_drained");
        tick();
        out_ready = 0; we = 1; wa = 3; wd = 5'h11;
        tick();
        wd = 5'h12;
        expect_val(SIG_OVLD, 1, "out_valid_set");
        expect_val(SIG_ODAT, 5'h11, "out_data_first");
        expect_val(SIG_OVF, 0, "out_no_ovf_yet");
        tick();
        we = 0;
        expect_val(SIG_ODAT, 5'h12, "out_overwrite");
        expect_val(SIG_OVF, 1, "out_ovf_set");
        expect_val(SIG_OVLD, 1, "out_valid_kept");
        out_ready = 1;
        out_q.push_back(5'h12);
        tick();
        out_ready = 0;
        expect_val(SIG_OVLD, 0, "out_drained");
        expect_val(SIG_OVF, 1, "out_ovf_sticky");
        tick();
        reset = 0;
        tick();
        reset = 1;
        expect_val(SIG_OVF, 0, "ovf_cleared_by_reset");
        we = 1; wa = 3; wd = 5'h0C;
        tick();
        we = 0;
        expect_val(SIG_OVLD, 1, "out_valid_0c");
        tick();
        out_ready = 1; we = 1; wa = 3; wd = 5'h03;
        out_q.push_back(5'h0C);
        tick();
        we = 0; out_ready = 0;
        expect_val(SIG_OVLD, 1, "same_cycle_valid");
        expect_val(SIG_ODAT, 5'h03, "same_cycle_data");
        expect_val(SIG_OVF, 0, "same_cycle_no_ovf");
        tick();
        out_ready = 1;
        out_q.push_back(5'h03);
        tick();
        out_ready = 0;
        expect_val(SIG_OVLD, 0, "out_drained_03");
        we = 1; wa = 1; wd = 5'h04;
        tick();
        wd = 5'h09; ra = 1; rb = 0;
`ifdef RF_BYPASS_EN
        expect_val(SIG_A, 5'h09, "rdw_a");
`else
        expect_val(SIG_A, 5'h04, "rdw_a");
`endif
        expect_val(SIG_B, 0, "rdw_b_other");
        tick();
        we = 0;
        expect_val(SIG_A, 5'h09, "rdw_after");
        in_valid8 = 1; in_data8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            we8 = 1; wa8 = 3'(i); wd8 = 8'h10 + 8'(i);
            tick();
            in_valid8 = 0;
        end
        we8 = 0; ra8 = 5;
        expect_val(SIG_FLAT8, 64'h1716_1514_13A5_1110, "flat8_order");
        expect_val(SIG_A8, 8'h15, "a8_read");
        tick();
        tick();
        n_chk++;
        if (out_q.size() != 0) begin
            n_fail++;
            $display("FAIL out_q_drain: %0d transfers missing, expected 0", out_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_param_io.md
Name: rf_param_io

Overview:
- Parametrised successor to the 4x5-bit CPU register file: N registers of W bits, two combinational read ports and one synchronous write port.
- One register is the input-port register, loaded only through a valid/ready handshake from the input device.
- Another register is the output-port register; writes to it raise a valid/ready handshake toward the output device.
- Sits between the CPU decode/ALU datapath and the I/O pins of the 5-bit CPU family.

Parameters:
W, 5, data width of every register and data port
N, 4, register count; power of two, at least 2; address width AW = clog2(N) is derived internally
IN_IDX, 2, index of the input-port register
OUT_IDX, 3, index of the output-port register; must differ from IN_IDX

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ra  input  AW  read address, port A
rb  input  AW  read address, port B
we  input  1  write enable
wa  input  AW  write address
wd  input  W  write data
a  output  W  read data, port A
b  output  W  read data, port B
in_data  input  W  input-device data
in_valid  input  1  input-device data valid
in_ready  output  1  input register can accept data
in_ack  input  1  core has consumed the input register (1-cycle pulse)
out_data  output  W  output-port register contents
out_valid  output  1  output register holds unsent data
out_ready  input  1  output device accepts data
out_ovf  output  1  sticky: unsent output data was overwritten
regs_flat  output  N*W  all registers, reg[i] at bits [i*W +: W], for debug/display

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear to 0 immediately.
  - in_full=0, so in_ready=1.
  - out_valid=0 and out_ovf=0.
  - Reset asserted mid-handshake aborts it; no transfer completes in that cycle.
- Reads:
  - a=reg[ra] and b=reg[rb], purely combinational.
  - Read-during-write returns the old value (unless RF_BYPASS_EN is defined).
- Writes:
  - On a rising clk edge with we=1, reg[wa]<=wd.
  - A write to wa==IN_IDX is ignored; the input register is owned by the input port.
  - we=0 holds all registers.
- Input port:
  - in_ready = ~in_full, combinational from state; no same-cycle pass-through.
  - Transfer on a clk edge where in_valid & in_ready: reg[IN_IDX]<=in_data, in_full<=1.
  - in_ack=1 while in_full=1: in_full<=0 at the edge, so in_ready=1 the next cycle. Register contents are retained (not cleared).
  - in_ack while empty: ignored.
  - in_valid while full: ignored (ready low); the data must be held by the source.
- Output port:
  - out_data = reg[OUT_IDX].
  - Write to OUT_IDX with out_valid=0: data written, out_valid<=1.
  - Handshake: out_valid & out_ready at an edge with no write to OUT_IDX gives out_valid<=0.
  - Write to OUT_IDX in the same cycle as a completing handshake: old data is taken, new data loads, out_valid stays 1, no overflow.
  - Write to OUT_IDX while out_valid=1 and out_ready=0: new data overwrites, out_valid stays 1, out_ovf<=1.
  - out_ovf is sticky until reset.
- Latency:
  - write-to-read: 1 cycle.
  - input accept to visibility on a/b: 1 cycle.
  - write to OUT_IDX to out_valid: 1 cycle.
- Address width is exactly AW bits, so no out-of-range addresses exist.

Optional Feature:
RF_BYPASS_EN
- Defined: write-through forwarding.
  - If we=1, wa==ra and wa!=IN_IDX, then a=wd in the same cycle; likewise b for rb.
  - Writes to IN_IDX are never forwarded.
- Undefined: no forwarding; reads during a write return the pre-edge value.
- Register state, handshakes and out_ovf are identical in both builds.

Test Plan:
- Reset, then we=1, wa=0, wd=5'h15; next cycle ra=0 -> a=5'h15. Reset low mid-run -> a=0, in_ready=1, out_valid=0 immediately.
- in_valid=1, in_data=5'h0A -> after edge in_ready=0 and reg2=5'h0A. in_data=5'h1F held with in_valid=1 -> reg2 stays 5'h0A. in_ack pulse -> in_ready=1 next cycle, then 5'h1F accepted.
- we=1, wa=IN_IDX=2, wd=5'h07 -> reg2 unchanged, rb=2 returns the last input value.
- Write 5'h11 to reg3 with out_ready=0 -> out_valid=1, out_data=5'h11. Write 5'h12 -> out_data=5'h12, out_ovf=1. out_ready=1 -> out_valid=0 after edge, out_ovf stays 1.
- out_valid=1, out_ready=1 and a write of 5'h03 to reg3 in the same cycle -> out_valid stays 1, out_data=5'h03, out_ovf=0.
- we=1, wa=1, wd=5'h09, ra=1 in the same cycle -> a=5'h09 with RF_BYPASS_EN, old value without it. Repeat with N=8, W=8 and check regs_flat ordering.
